// File: rtl/hps_lw_test_slave.sv
// -----------------------------------------------------------------------------
// hps_lw_test_slave
//
// Avalon-MM register slave on the HPS lightweight bridge. It gives HPS
// software a fixed ID word, a scratch register, a controllable free-running
// counter, LED drive bits and write/read transaction counters, so bridge
// accesses can be proven end to end.
//
// Reads are accepted in a single cycle and return data after a fixed
// READ_LATENCY cycles. While a read is in flight the slave holds
// avs_waitrequest high and ignores further requests.
//
// Register map (word address):
//   0 ID       RO  ID_VALUE
//   1 SCRATCH  RW  byte-enabled
//   2 CTRL     bit0 EN (RW), bit1 CLR (write-1 pulse, reads 0),
//              bit2 IRQ_PEND (W1C, only with HPS_LW_TEST_IRQ_EN)
//   3 COUNT    RO  free-running counter, runs while EN=1
//   4 LED      RW  bits[9:0] drive led
//   5 WRCNT    RO  accepted writes
//   6 RDCNT    RO  accepted reads (value returned is pre-increment)
//   7 COMPARE  RW  with HPS_LW_TEST_IRQ_EN, otherwise reads 0
//
// Optional feature macro: HPS_LW_TEST_IRQ_EN
//   Adds the irq output, the COMPARE register and CTRL.IRQ_PEND.
//
// Parameters:
//   ID_VALUE      constant returned at word 0
//   READ_LATENCY  cycles from read acceptance to avs_readdatavalid (1..4)
//
// Ports:
//   clk                in   bridge clock
//   reset              in   synchronous, active-high
//   avs_address[2:0]   in   word address
//   avs_read           in   read request
//   avs_write          in   write request
//   avs_writedata[31:0]in   write data
//   avs_byteenable[3:0]in   byte lanes (SCRATCH only)
//   avs_readdata[31:0] out  read data, 0 unless avs_readdatavalid
//   avs_readdatavalid  out  one-cycle read response strobe
//   avs_waitrequest    out  stall
//   led[9:0]           out  LED drive
//   irq                out  IRQ_PEND (HPS_LW_TEST_IRQ_EN only)
// -----------------------------------------------------------------------------
module hps_lw_test_slave #(
    parameter logic [31:0] ID_VALUE     = 32'hB81D_7E57,
    parameter int          READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic [3:0]  avs_byteenable,
    output logic [31:0] avs_readdata,
    output logic        avs_readdatavalid,
    output logic        avs_waitrequest,
    output logic [9:0]  led
`ifdef HPS_LW_TEST_IRQ_EN
    ,
    output logic        irq
`endif
);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("hps_lw_test_slave: READ_LATENCY must be in 1..4");
    end

    // The latency counter is loaded with READ_LATENCY-1 on acceptance so
    // that RBUSY lasts exactly READ_LATENCY cycles; the response is issued
    // in the RBUSY cycle where the counter reads zero.
    localparam logic [2:0] LAT_LOAD = 3'(READ_LATENCY - 1);

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_SCRATCH = 3'd1;
    localparam logic [2:0] ADDR_CTRL    = 3'd2;
    localparam logic [2:0] ADDR_COUNT   = 3'd3;
    localparam logic [2:0] ADDR_LED     = 3'd4;
    localparam logic [2:0] ADDR_WRCNT   = 3'd5;
    localparam logic [2:0] ADDR_RDCNT   = 3'd6;
    localparam logic [2:0] ADDR_COMPARE = 3'd7;

    typedef enum logic {
        IDLE  = 1'b0,
        RBUSY = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [2:0]  lat_cnt;
    logic [2:0]  lat_cnt_next;
    logic        rd_accept;
    logic        wr_accept;
    logic        rsp_fire;

    logic [31:0] scratch;
    logic        ctrl_en;
    logic        ctrl_irq_pend;
    logic [31:0] count;
    logic [9:0]  led_reg;
    logic [31:0] wrcnt;
    logic [31:0] rdcnt;
    logic [31:0] compare;
    logic [31:0] snapshot;
    logic [31:0] rd_value;

    logic        wr_scratch;
    logic        wr_ctrl;
    logic        wr_led;
    logic        count_clr;

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
        end else begin
            state   <= state_next;
            lat_cnt <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next   = state;
        lat_cnt_next = lat_cnt;
        rd_accept    = 1'b0;
        wr_accept    = 1'b0;
        rsp_fire     = 1'b0;
        case (state)
            IDLE: begin
                // A simultaneous read and write is serviced as a read only.
                if (avs_read) begin
                    rd_accept    = 1'b1;
                    lat_cnt_next = LAT_LOAD;
                    state_next   = RBUSY;
                end else if (avs_write) begin
                    wr_accept = 1'b1;
                end
            end
            RBUSY: begin
                if (lat_cnt == 3'd0) begin
                    rsp_fire   = 1'b1;
                    state_next = IDLE;
                end else begin
                    lat_cnt_next = lat_cnt - 3'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Waitrequest is forced high straight from reset so the bridge never
    // sees the slave as ready while it is being reset. The response strobe
    // is masked by reset so an abandoned read never produces a response.
    assign avs_waitrequest   = reset | (state == RBUSY);
    assign avs_readdatavalid = rsp_fire & ~reset;
    assign avs_readdata      = avs_readdatavalid ? snapshot : 32'd0;

    // ------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------
    assign wr_scratch = wr_accept && (avs_address == ADDR_SCRATCH);
    assign wr_ctrl    = wr_accept && (avs_address == ADDR_CTRL);
    assign wr_led     = wr_accept && (avs_address == ADDR_LED);
    assign count_clr  = wr_ctrl && avs_writedata[1];

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            scratch <= '0;
        end else if (wr_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (avs_byteenable[b]) begin
                    scratch[8*b +: 8] <= avs_writedata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en <= 1'b0;
            led_reg <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= avs_writedata[0];
            end
            if (wr_led) begin
                led_reg <= avs_writedata[9:0];
            end
        end
    end

    // Clear takes priority over increment; the increment uses the EN value
    // held before this edge, so EN=1 with CLR=1 leaves COUNT at zero for one
    // cycle and counting resumes on the following edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count_clr) begin
            count <= '0;
        end else if (ctrl_en) begin
            count <= count + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrcnt <= '0;
            rdcnt <= '0;
        end else begin
            if (wr_accept) begin
                wrcnt <= wrcnt + 32'd1;
            end
            if (rd_accept) begin
                rdcnt <= rdcnt + 32'd1;
            end
        end
    end

`ifdef HPS_LW_TEST_IRQ_EN
    logic wr_compare;
    logic irq_set;
    logic irq_clr;

    assign wr_compare = wr_accept && (avs_address == ADDR_COMPARE);
    assign irq_set    = ctrl_en && (count == compare);
    assign irq_clr    = wr_ctrl && avs_writedata[2];

    always_ff @(posedge clk) begin
        if (reset) begin
            compare <= '0;
        end else if (wr_compare) begin
            compare <= avs_writedata;
        end
    end

    // A match on the same edge as a software clear keeps the flag set so
    // that no event can be lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_irq_pend <= 1'b0;
        end else if (irq_set) begin
            ctrl_irq_pend <= 1'b1;
        end else if (irq_clr) begin
            ctrl_irq_pend <= 1'b0;
        end
    end

    assign irq = ctrl_irq_pend;
`else
    assign compare       = '0;
    assign ctrl_irq_pend = 1'b0;
`endif

    assign led = led_reg;

    // ------------------------------------------------------------------
    // Read path: the addressed value is captured on the accepting edge,
    // so RDCNT returns its pre-increment value.
    // ------------------------------------------------------------------
    always_comb begin
        rd_value = 32'd0;
        case (avs_address)
            ADDR_ID:      rd_value = ID_VALUE;
            ADDR_SCRATCH: rd_value = scratch;
            ADDR_CTRL:    rd_value = {29'd0, ctrl_irq_pend, 1'b0, ctrl_en};
            ADDR_COUNT:   rd_value = count;
            ADDR_LED:     rd_value = {22'd0, led_reg};
            ADDR_WRCNT:   rd_value = wrcnt;
            ADDR_RDCNT:   rd_value = rdcnt;
            ADDR_COMPARE: rd_value = compare;
            default:      rd_value = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            snapshot <= '0;
        end else if (rd_accept) begin
            snapshot <= rd_value;
        end
    end

endmodule

// File: doc/hps_lw_test_slave.md
# hps_lw_test_slave

FPGA-side Avalon-MM register slave on the HPS lightweight bridge exported from `soc_system`. It gives HPS software a known ID word, a scratch register, a controllable free-running counter, LED drive bits and transaction counters, so bridge reads and writes can be proven end to end. Read data comes back with a fixed, parameterised latency, and the slave holds `avs_waitrequest` high while a read is in flight.

## Interface
- `ID_VALUE`, default 32'hB81D_7E57: constant returned at word 0.
- `READ_LATENCY`, default 2, legal range 1..4: cycles from read acceptance to `avs_readdatavalid`.
- `clk` in 1: single clock; the bridge clock domain.
- `reset` in 1: synchronous, active-high.
- `avs_address` in 3: word address.
- `avs_read` in 1: read request.
- `avs_write` in 1: write request.
- `avs_writedata` in 32: write data.
- `avs_byteenable` in 4: byte lanes; honoured only by SCRATCH.
- `avs_readdata` out 32: read data; valid only while `avs_readdatavalid` is high, 0 otherwise.
- `avs_readdatavalid` out 1: one-cycle read response strobe.
- `avs_waitrequest` out 1: stall.
- `led` out 10: LED drive.

## Operation
Register map (word address):
- 0 ID: RO, returns `ID_VALUE`.
- 1 SCRATCH: RW, byte-enabled, reset value 0.
- 2 CTRL:
  - bit0 EN: RW, reset 0.
  - bit1 CLR: write-1 pulse, reads 0.
  - Other bits read 0.
- 3 COUNT: RO, 32-bit.
  - Increments each cycle while EN=1 and wraps FFFF_FFFF→0.
  - A CLR write zeroes it on the next edge; clear beats increment.
- 4 LED: RW, bits[9:0] drive `led` directly, reset 0, upper bits read 0.
- 5 WRCNT: RO, count of accepted writes, wraps.
- 6 RDCNT: RO, count of accepted reads, wraps. The value returned is the pre-increment value.
- 7: reads 0, writes ignored (see Configuration).

FSM with states IDLE and RBUSY.
- **IDLE:** `avs_waitrequest`=0.
  - Write: accepted in the same cycle. The register updates at the closing edge and WRCNT increments. The state stays IDLE.
  - Read: accepted in the same cycle. The addressed value is snapshotted at that edge, RDCNT increments and the state goes to RBUSY.
  - `avs_read` and `avs_write` both high: treated as a read only. The write is dropped and WRCNT is unchanged.
- **RBUSY:** `avs_waitrequest`=1 and requests are ignored.
  - A down-counter runs READ_LATENCY cycles.
  - In the last RBUSY cycle, `avs_readdatavalid`=1 with the snapshot on `avs_readdata`.
  - The state then returns to IDLE.
- Writes to RO addresses are accepted (WRCNT increments) with no register change.

## Timing
- Read accepted in cycle k:
  - `avs_waitrequest` is high in cycles k+1..k+READ_LATENCY.
  - `avs_readdatavalid` is high in cycle k+READ_LATENCY only.
  - The next request can be accepted at cycle k+READ_LATENCY+1.
  - Back-to-back throughput is one read per READ_LATENCY+1 cycles.
- Write accepted in cycle k: the new value is readable by a read issued in cycle k+1.
- Reset state: FSM IDLE, all registers 0, `avs_waitrequest`=1 while `reset`=1, all other outputs 0.
- Reset asserted in RBUSY:
  - The pending read is abandoned with no `avs_readdatavalid`.
  - `avs_waitrequest` drops the first cycle after `reset` deasserts.
- A CTRL write with EN=1 and CLR=1: COUNT goes to 0, then counts from the following cycle.

## Configuration
- Macro `HPS_LW_TEST_IRQ_EN` defined:
  - Adds output port `irq` (1 bit).
  - Adds COMPARE at word 7: RW, reset 0.
  - Adds CTRL bit2 IRQ_PEND: set on the edge where EN=1 and COUNT==COMPARE; write-1-to-clear; set wins over a simultaneous clear.
  - `irq` = IRQ_PEND.
- Macro undefined: no `irq` port, word 7 reads 0, CTRL bit2 reads 0.

## Test plan
- **Reset and ID:** `reset` high 3 cycles, then read word 0 with READ_LATENCY=2 → `avs_waitrequest`=1 during reset; readdatavalid 2 cycles after accept with 32'hB81D_7E57.
- **Scratch byte enables:** write 32'h1122_3344 with be=4'hF, then write 32'hAAAA_AAAA with be=4'b0101 → read returns 32'h11AA_33AA. WRCNT=2 and RDCNT reads 1 on a second read.
- **Counter:** write CTRL=1, wait 10 cycles, write CTRL=3 → COUNT read immediately after is ≤ latency-dependent small value (golden model exact). Write CTRL=0 → two successive COUNT reads are equal.
- **LED and collision:** drive read+write to word 4 with data 10'h3FF → `led` unchanged, readdatavalid fires, WRCNT unchanged.
- **Reset mid-read:** accept a read and assert `reset` at k+1 → no readdatavalid; `avs_waitrequest`=0 the cycle after release.
- **IRQ (macro on):** COMPARE=5, CTRL=3 → `irq` rises when COUNT==5; write CTRL=32'h5 → `irq` falls next edge.
